// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants, op bit positions and FSM states for the multiply/divide unit
//   OP_DIV_BIT       op bit selecting divide (1) or multiply (0)
//   OP_UNS_BIT       op bit selecting unsigned operation (honoured only with MULDIV_UNSIGNED_EN)
//   MULDIV_MIN_WIDTH / MULDIV_MAX_WIDTH  legal operand width range
package muldiv_pkg;
    localparam int MULDIV_MIN_WIDTH = 8;
    localparam int MULDIV_MAX_WIDTH = 64;
    localparam int OP_DIV_BIT = 0;
    localparam int OP_UNS_BIT = 1;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
endpackage

// File: rtl/muldiv_iter_step.sv
// muldiv_iter_step: one combinational shift-add (multiply) or restoring shift-subtract (divide) iteration
//   div      1 = divide step, 0 = multiply step
//   hi, lo   current accumulator halves (multiply: partial product / multiplier, divide: remainder / dividend-quotient)
//   m        multiplicand magnitude or divisor magnitude
//   hi_next, lo_next  accumulator after this iteration
module muldiv_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic             div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] rem;
    logic             borrow;
    logic             unused_top;

    // Remainder is always below the divisor, so bit WIDTH of the difference is never needed.
    assign sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    assign sh  = {hi, lo[WIDTH-1]};
    assign {borrow, unused_top, rem} = {1'b0, sh} - {2'b00, m};

    assign hi_next = div ? (borrow ? sh[WIDTH-1:0] : rem) : sum[WIDTH:1];
    assign lo_next = div ? {lo[WIDTH-2:0], ~borrow} : {sum[0], lo[WIDTH-1:1]};
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative signed (optionally unsigned) multiply/divide, fixed WIDTH+2 edge latency
//   clk, reset (async, active low)
//   start, op[1:0] (bit0 divide, bit1 unsigned), abort, a, b   request side
//   busy, done, div_zero, hi_out, lo_out                       result side
//   Macro MULDIV_UNSIGNED_EN enables unsigned operation via op[1].
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   acc_hi, acc_lo, m, step_hi, step_lo, ma, mb, fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod;
    logic               is_div, neg_q, neg_r, dz, uns, sa, sb;

`ifdef MULDIV_UNSIGNED_EN
    assign uns = op[OP_UNS_BIT];
`else
    logic unused_op;
    assign uns = 1'b0;
    assign unused_op = op[OP_UNS_BIT];
`endif

    // Magnitudes at accept; the most-negative value maps onto its unsigned magnitude.
    assign sa = ~uns & a[WIDTH-1];
    assign sb = ~uns & b[WIDTH-1];
    assign ma = sa ? -a : a;
    assign mb = sb ? -b : b;

    muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
        .div    (is_div),
        .hi     (acc_hi),
        .lo     (acc_lo),
        .m      (m),
        .hi_next(step_hi),
        .lo_next(step_lo)
    );

    // With a zero divisor the remainder path already yields |dividend|; the sign fix restores the dividend.
    assign prod   = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign fix_hi = is_div ? (neg_r ? -acc_hi : acc_hi) : prod[2*WIDTH-1:WIDTH];
    assign fix_lo = is_div ? (dz ? '1 : (neg_q ? -acc_lo : acc_lo)) : prod[WIDTH-1:0];

    assign busy = state != IDLE;
    assign done = state == DONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // CALC lasts WIDTH+1 cycles: WIDTH iterations, then the count reaching WIDTH moves to FIX.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = start ? CALC : IDLE;
            CALC: state_next = abort ? IDLE : (cnt == CW'(WIDTH) ? FIX : CALC);
            FIX:  state_next = abort ? IDLE : DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            m        <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            div_zero <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else if (state == IDLE && start) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= op[OP_DIV_BIT] ? ma : mb;
            m      <= op[OP_DIV_BIT] ? mb : ma;
            is_div <= op[OP_DIV_BIT];
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            dz     <= op[OP_DIV_BIT] && b == '0;
        end else if (state == CALC && cnt != CW'(WIDTH)) begin
            cnt    <= cnt + 1'b1;
            acc_hi <= step_hi;
            acc_lo <= step_lo;
        end else if (state == FIX && !abort) begin
            hi_out   <= fix_hi;
            lo_out   <= fix_lo;
            div_zero <= dz;
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vector table plus hand sequences for busy-start, abort and mid-op reset
module tb_mul_div_unit;
    localparam int W = 32;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic        dz;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi_out, lo_out;

    int errors = 0;
    int checks = 0;
    vec_t vecs[14];

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .abort   (abort),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .div_zero(div_zero),
        .hi_out  (hi_out),
        .lo_out  (lo_out)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Presents a request for edge 0, then scrambles a/b/op, which must be ignored from here on.
    task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic ab);
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        abort = ab;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 2'($urandom);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            n++;
            #1;
            if (done) break;
        end
    endtask

    initial begin
        int n, pulses, at;
        logic [W-1:0] lo_s;

        vecs[0]  = '{"mul_7_m3",     2'b00, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{"div_m7_2",     2'b01, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[2]  = '{"div_ovf",      2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0};
        vecs[3]  = '{"div_5_0",      2'b01, 32'h5,        32'h0,        32'h5,        32'hFFFFFFFF, 1'b1};
        vecs[4]  = '{"mul_zero",     2'b00, 32'h0,        32'h12345,    32'h0,        32'h0,        1'b0};
        vecs[5]  = '{"mul_min_min",  2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0};
        vecs[6]  = '{"div_100_7",    2'b01, 32'd100,      32'd7,        32'h2,        32'hE,        1'b0};
        vecs[7]  = '{"div_7_m2",     2'b01, 32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{"div_m7_0",     2'b01, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[9]  = '{"mul_2p16_sq",  2'b00, 32'h10000,    32'h10000,    32'h1,        32'h0,        1'b0};
`ifdef MULDIV_UNSIGNED_EN
        vecs[10] = '{"umul_ff_2",    2'b10, 32'hFFFFFFFF, 32'h2,        32'h1,        32'hFFFFFFFE, 1'b0};
        vecs[11] = '{"udiv_ff_2",    2'b11, 32'hFFFFFFFF, 32'h2,        32'h1,        32'h7FFFFFFF, 1'b0};
`else
        vecs[10] = '{"umul_ff_2",    2'b10, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
        vecs[11] = '{"udiv_ff_2",    2'b11, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'h0,        1'b0};
`endif
        vecs[12] = '{"udiv_7_0",     2'b11, 32'h7,        32'h0,        32'h7,        32'hFFFFFFFF, 1'b1};
        vecs[13] = '{"mul_min_max",  2'b00, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000, 1'b0};

        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_flags", {61'd0, busy, done, div_zero}, 64'd0);
        check("reset_hi", hi_out, 64'd0);
        check("reset_lo", lo_out, 64'd0);
        reset = 1'b1;

        // Second start at edge 10 while busy must be dropped.
        launch(2'b00, 32'h7, 32'hFFFFFFFD, 1'b0);
        pulses = 0;
        at = 0;
        lo_s = '0;
        for (int e = 1; e <= 40; e++) begin
            start = (e == 10);
            if (e == 10) begin
                op = 2'b00;
                a = 32'h2;
                b = 32'h2;
            end
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                at = e;
                lo_s = lo_out;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_start_pulses", 64'(pulses), 64'd1);
        check("busy_start_edge", 64'(at), 64'd34);
        check("busy_start_lo", lo_s, 64'hFFFFFFEB);
        check("busy_start_idle", {63'd0, busy}, 64'd0);

        // Abort at edge 15: no pulse, previous results retained.
        launch(2'b00, 32'h3, 32'h3, 1'b0);
        pulses = 0;
        for (int e = 1; e <= 40; e++) begin
            abort = (e == 15);
            @(posedge clk);
            #1;
            if (done) pulses++;
            @(negedge clk);
        end
        abort = 1'b0;
        check("abort_pulses", 64'(pulses), 64'd0);
        check("abort_hi_held", hi_out, 64'hFFFFFFFF);
        check("abort_lo_held", lo_out, 64'hFFFFFFEB);
        check("abort_idle", {63'd0, busy}, 64'd0);

        // Reset low just after edge 20 of a new operation.
        launch(2'b00, 32'h4, 32'h4, 1'b0);
        repeat (20) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("midreset_flags", {61'd0, busy, done, div_zero}, 64'd0);
        check("midreset_hi", hi_out, 64'd0);
        check("midreset_lo", lo_out, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("midreset_no_done", 64'(pulses), 64'd0);

        // Vector table; vector 2 also raises abort in the accepting cycle, where start must win.
        for (int i = 0; i < 14; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b, i == 2);
            check({vecs[i].name, "_busy"}, {63'd0, busy}, 64'd1);
            wait_done(n);
            check({vecs[i].name, "_latency"}, 64'(n), 64'd34);
            check({vecs[i].name, "_hi"}, hi_out, vecs[i].hi);
            check({vecs[i].name, "_lo"}, lo_out, vecs[i].lo);
            check({vecs[i].name, "_dz"}, {63'd0, div_zero}, {63'd0, vecs[i].dz});
            @(posedge clk);
            #1;
            check({vecs[i].name, "_idle"}, {62'd0, done, busy}, 64'd0);
            check({vecs[i].name, "_lo_held"}, lo_out, vecs[i].lo);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
